// File: rtl/clk_div_pkg.sv
// Shared constants and the per-channel configuration record for the divider bank.
package clk_div_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int TERM_DEF  = 39;
  localparam int HIGH_DEF  = 20;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] term;
    logic [CNT_W_DEF-1:0] high;
  } ch_cfg_t;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, shadowed term/high config, registered
// divided clock and rising-edge strobe.
module clk_div_ch #(
  parameter int               CNT_W = 8,
  parameter logic [CNT_W-1:0] DEF_T = '0,
  parameter logic [CNT_W-1:0] DEF_H = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_term,
  input  logic [CNT_W-1:0] i_high,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_pending
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_term_a;
  logic [CNT_W-1:0] r_high_a;
  logic [CNT_W-1:0] r_term_p;
  logic [CNT_W-1:0] r_high_p;
  logic             r_pend;
  logic             r_en_d;
  logic             r_clk;
  logic             r_rise;

  logic [CNT_W-1:0] w_term_eff;
  logic [CNT_W-1:0] w_term_n;
  logic [CNT_W-1:0] w_high_n;
  logic [CNT_W-1:0] w_teff_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_wrap;
  logic             w_restart;
  logic             w_apply;
  logic             w_clk_n;

  // A terminal count of 0 behaves as 1 so the period never drops below two cycles.
  assign w_term_eff = (r_term_a == '0) ? CNT_W'(1) : r_term_a;
  assign w_wrap     = i_en && (r_cnt >= w_term_eff);
  assign w_restart  = i_sync || (i_en && !r_en_d);
  // A disabled channel has no period in flight, so it is always at a boundary.
  assign w_apply    = w_wrap || i_sync || !i_en;

  assign w_cnt_n = (!i_en || w_restart || w_wrap) ? '0 : r_cnt + CNT_W'(1);

  always_comb begin
    w_term_n = r_term_a;
    w_high_n = r_high_a;
    if (w_apply && i_load) begin
      w_term_n = i_term;
      w_high_n = i_high;
    end else if (w_apply && r_pend) begin
      w_term_n = r_term_p;
      w_high_n = r_high_p;
    end
  end

  assign w_teff_n = (w_term_n == '0) ? CNT_W'(1) : w_term_n;
  // High when cnt >= T+1-H, rearranged to avoid underflow when H > T.
  assign w_clk_n  = i_en &&
                    (({1'b0, w_cnt_n} + {1'b0, w_high_n}) >= ({1'b0, w_teff_n} + (CNT_W+1)'(1)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_term_a <= DEF_T;
      r_high_a <= DEF_H;
      r_term_p <= '0;
      r_high_p <= '0;
      r_pend   <= 1'b0;
      r_en_d   <= 1'b0;
      r_clk    <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_n;
      r_term_a <= w_term_n;
      r_high_a <= w_high_n;
      r_en_d   <= i_en;
      r_clk    <= w_clk_n;
      r_rise   <= w_clk_n && !r_clk;
      if (i_load) begin
        r_term_p <= i_term;
        r_high_p <= i_high;
      end
      if (w_apply) begin
        r_pend <= 1'b0;
      end else if (i_load) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign o_clk     = r_clk;
  assign o_rise    = r_rise;
  assign o_pending = r_pend;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing one clock, reset and
// phase-align strobe.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_TERM = TERM_DEF,
  parameter int DEF_HIGH = HIGH_DEF
) (
  input  logic                  clk80,
  input  logic                  reset,
  input  logic [N_CH-1:0]       en,
  input  logic                  sync,
  input  logic [N_CH-1:0]       cfg_load,
  input  logic [N_CH*CNT_W-1:0] cfg_term,
  input  logic [N_CH*CNT_W-1:0] cfg_high,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       rise,
  output logic [N_CH-1:0]       cfg_pending
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    clk_div_ch #(
      .CNT_W (CNT_W),
      .DEF_T (CNT_W'(DEF_TERM)),
      .DEF_H (CNT_W'(DEF_HIGH))
    ) u_ch (
      .i_clk     (clk80),
      .i_reset   (reset),
      .i_en      (en[c]),
      .i_sync    (sync),
      .i_load    (cfg_load[c]),
      .i_term    (cfg_term[c*CNT_W +: CNT_W]),
      .i_high    (cfg_high[c*CNT_W +: CNT_W]),
      .o_clk     (clk_out[c]),
      .o_rise    (rise[c]),
      .o_pending (cfg_pending[c])
    );
  end

endmodule
